// File: rtl/game_timer.sv
// Round countdown timer: synchronises the game FSM's state/enable, starts on entry to the
// guessing state and counts whole seconds down, flagging expiry to the FSM.
module game_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TIME_W        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        state,
    input  logic              time_f,
    input  logic [TIME_W-1:0] time_v,
    output logic              end_f,
    output logic [TIME_W-1:0] time_left,
    output logic              running,
    output logic              sec_tick
);

    localparam int unsigned     PW   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [1:0]      StateReady = 2'd1;
    localparam logic [1:0]      StateGuess = 2'd2;

    typedef enum logic [1:0] {StIdle, StRun, StExpired} tmr_state_e;

    logic [1:0]  st_s1, st_s2, st_prev, fs, fs_last;
    logic        tf_s1, tf_s2, tf_prev, ff;
    logic [1:0]  vcnt;
    logic        armed;
    logic        start;
    logic [PW-1:0] presc;
    tmr_state_e  tst;

    // Filters only load once the synchroniser pipeline holds real samples, and the timer
    // is armed only after a genuine non-guessing state has been seen since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_s1   <= '0;
            st_s2   <= '0;
            st_prev <= '0;
            fs      <= '0;
            fs_last <= '0;
            tf_s1   <= 1'b0;
            tf_s2   <= 1'b0;
            tf_prev <= 1'b0;
            ff      <= 1'b0;
            vcnt    <= '0;
            armed   <= 1'b0;
        end else begin
            st_s1   <= state;
            st_s2   <= st_s1;
            st_prev <= st_s2;
            tf_s1   <= time_f;
            tf_s2   <= tf_s1;
            tf_prev <= tf_s2;
            fs_last <= fs;
            if (vcnt != 2'd3) begin
                vcnt <= vcnt + 2'd1;
            end
            if (vcnt == 2'd3 && st_s2 == st_prev) begin
                fs <= st_s2;
                if (st_s2 != StateGuess) begin
                    armed <= 1'b1;
                end
            end
            if (vcnt == 2'd3 && tf_s2 == tf_prev) begin
                ff <= tf_s2;
            end
        end
    end

    assign start = armed && ff && (fs == StateGuess) && (fs_last != StateGuess);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tst       <= StIdle;
            end_f     <= 1'b0;
            time_left <= '0;
            running   <= 1'b0;
            sec_tick  <= 1'b0;
            presc     <= '0;
        end else begin
            sec_tick <= 1'b0;
            if (start) begin
                time_left <= time_v;
                presc     <= '0;
                if (time_v == '0) begin
                    tst     <= StExpired;
                    running <= 1'b0;
                    end_f   <= 1'b1;
                end else begin
                    tst     <= StRun;
                    running <= 1'b1;
                    end_f   <= 1'b0;
                end
            end else begin
                unique case (tst)
                    StRun: begin
                        // A guess landing on the final-tick cycle beats expiry.
                        if (fs != StateGuess) begin
                            tst     <= StIdle;
                            running <= 1'b0;
                            presc   <= '0;
                        end else if (presc == PMAX) begin
                            presc     <= '0;
                            time_left <= time_left - TIME_W'(1);
                            sec_tick  <= 1'b1;
                            if (time_left == TIME_W'(1)) begin
                                tst     <= StExpired;
                                running <= 1'b0;
                                end_f   <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    StExpired: begin
                        if (fs == StateReady) begin
                            tst   <= StIdle;
                            end_f <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: expected output events are queued with the stimulus
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_game_timer;

    localparam int unsigned TPS = 4;
    localparam int unsigned TW  = 5;

    localparam int EvRunUp = 0;
    localparam int EvRunDn = 1;
    localparam int EvTick  = 2;
    localparam int EvEndUp = 3;
    localparam int EvEndDn = 4;

    typedef struct {
        int kind;
        int tl;
        bit ef;
        bit rn;
        int dt;
    } ev_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic [1:0]    state  = 2'd0;
    logic          time_f = 1'b0;
    logic [TW-1:0] time_v = '0;
    logic          end_f;
    logic [TW-1:0] time_left;
    logic          running;
    logic          sec_tick;

    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    rise_cyc = 0;
    bit    prev_run = 1'b0;
    bit    prev_end = 1'b0;
    ev_t   sb[$];
    string kname [5] = '{"run_up", "run_dn", "tick", "end_up", "end_dn"};

    always #5 clk = ~clk;

    game_timer #(.TICKS_PER_SEC(TPS), .TIME_W(TW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .time_f   (time_f),
        .time_v   (time_v),
        .end_f    (end_f),
        .time_left(time_left),
        .running  (running),
        .sec_tick (sec_tick)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int k, int tl, bit ef, bit rn, int dt);
        ev_t e;
        e.kind = k;
        e.tl   = tl;
        e.ef   = ef;
        e.rn   = rn;
        e.dt   = dt;
        sb.push_back(e);
    endfunction

    function automatic void observe(int k, int dt);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s tl=%0d end_f=%0b running=%0b dt=%0d, required none",
                     kname[k], time_left, end_f, running, dt);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.tl != int'(time_left) || e.ef != end_f || e.rn != running ||
                (e.dt >= 0 && e.dt != dt)) begin
                errors++;
                $display("FAIL event_%s: got %s tl=%0d end_f=%0b running=%0b dt=%0d, required %s tl=%0d end_f=%0b running=%0b dt=%0d",
                         kname[e.kind], kname[k], time_left, end_f, running, dt,
                         kname[e.kind], e.tl, e.ef, e.rn, e.dt);
            end
        end
    endfunction

    // Fixed intra-cycle event order: run_up, tick, end_up, end_dn, run_dn.
    always @(negedge clk) begin
        if (running && !prev_run) begin
            rise_cyc = cyc;
            observe(EvRunUp, 0);
        end
        if (sec_tick)              observe(EvTick, cyc - rise_cyc);
        if (end_f && !prev_end)    observe(EvEndUp, cyc - rise_cyc);
        if (!end_f && prev_end)    observe(EvEndDn, cyc - rise_cyc);
        if (!running && prev_run)  observe(EvRunDn, cyc - rise_cyc);
        prev_run = running;
        prev_end = end_f;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input int tl, input bit ef, input bit rn);
        checks++;
        if (int'(time_left) != tl || end_f != ef || running != rn || sec_tick != 1'b0) begin
            errors++;
            $display("FAIL %s: got tl=%0d end_f=%0b running=%0b sec_tick=%0b, required tl=%0d end_f=%0b running=%0b sec_tick=0",
                     name, time_left, end_f, running, sec_tick, tl, ef, rn);
        end
    endtask

    // which: 0 waits for running, 1 for end_f; cycles counted from the input drive.
    task automatic wait_sig(input int which, input int lo, input int hi, input string name);
        int n;
        n = 0;
        while (n < 30) begin
            tick(1);
            n++;
            if ((which == 0 && running) || (which == 1 && end_f)) break;
        end
        checks++;
        if (n < lo || n > hi) begin
            errors++;
            $display("FAIL %s: got %0d cycles, required %0d..%0d", name, n, lo, hi);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        tick(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d events outstanding (next %s), required 0",
                     name, sb.size(), kname[sb[0].kind]);
            sb.delete();
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_outs("reset_state", 0, 1'b0, 1'b0);
        tick(3);
        rst_n = 1'b1;

        // Normal expiry
        state = 2'd1; time_f = 1'b1; time_v = 5'd3;
        tick(8);
        push(EvRunUp, 3, 1'b0, 1'b1, 0);
        push(EvTick,  2, 1'b0, 1'b1, 4);
        push(EvTick,  1, 1'b0, 1'b1, 8);
        push(EvTick,  0, 1'b1, 1'b0, 12);
        push(EvEndUp, 0, 1'b1, 1'b0, 12);
        push(EvRunDn, 0, 1'b1, 1'b0, 12);
        state = 2'd2;
        wait_sig(0, 4, 5, "start_latency");
        drain("expiry");
        check_outs("expired_hold", 0, 1'b1, 1'b0);
        state = 2'd3;
        tick(8);
        check_outs("lost_no_clear", 0, 1'b1, 1'b0);

        // Clear and rearm
        push(EvEndDn, 0, 1'b0, 1'b0, -1);
        state = 2'd1;
        tick(8);
        drain("clear");
        time_v = 5'd5;
        push(EvRunUp, 5, 1'b0, 1'b1, 0);
        push(EvTick,  4, 1'b0, 1'b1, 4);
        push(EvRunDn, 4, 1'b0, 1'b0, 7);
        state = 2'd2;
        wait_sig(0, 4, 5, "rearm_latency");
        tick(2);
        state = 2'd1;
        drain("rearm");
        check_outs("rearm_stop", 4, 1'b0, 1'b0);

        // Early guess
        time_v = 5'd3;
        push(EvRunUp, 3, 1'b0, 1'b1, 0);
        push(EvTick,  2, 1'b0, 1'b1, 4);
        push(EvRunDn, 2, 1'b0, 1'b0, 7);
        state = 2'd2;
        wait_sig(0, 4, 5, "guess_latency");
        tick(2);
        state = 2'd1;
        drain("guess");
        check_outs("guess_frozen", 2, 1'b0, 1'b0);

        // Stop lands on the final-tick cycle
        push(EvRunUp, 3, 1'b0, 1'b1, 0);
        push(EvTick,  2, 1'b0, 1'b1, 4);
        push(EvTick,  1, 1'b0, 1'b1, 8);
        push(EvRunDn, 1, 1'b0, 1'b0, 12);
        state = 2'd2;
        wait_sig(0, 4, 5, "collide_latency");
        tick(7);
        state = 2'd1;
        drain("collide");
        check_outs("collide_final", 1, 1'b0, 1'b0);

        // Zero duration
        time_v = 5'd0;
        push(EvEndUp, 0, 1'b1, 1'b0, -1);
        state = 2'd2;
        wait_sig(1, 4, 5, "zero_end_latency");
        drain("zero");
        check_outs("zero_expired", 0, 1'b1, 1'b0);
        push(EvEndDn, 0, 1'b0, 1'b0, -1);
        state = 2'd1;
        tick(6);
        drain("zero_clear");

        // Missing enable, then late enable inside the same guessing period
        time_f = 1'b0; time_v = 5'd3;
        tick(8);
        state = 2'd2;
        tick(12);
        check_outs("no_enable", 0, 1'b0, 1'b0);
        time_f = 1'b1;
        tick(12);
        check_outs("late_enable", 0, 1'b0, 1'b0);
        state = 2'd1;
        tick(8);
        drain("enable");

        // Reset mid-count
        time_v = 5'd5;
        push(EvRunUp, 5, 1'b0, 1'b1, 0);
        push(EvTick,  4, 1'b0, 1'b1, 4);
        push(EvRunDn, 0, 1'b0, 1'b0, -1);
        state = 2'd2;
        wait_sig(0, 4, 5, "pre_reset_latency");
        tick(5);
        #2 rst_n = 1'b0;
        #1 check_outs("async_reset", 0, 1'b0, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check_outs("no_restart", 0, 1'b0, 1'b0);
        drain("reset");

        // Re-entry into state 2 after reset does start
        push(EvRunUp, 5, 1'b0, 1'b1, 0);
        push(EvTick,  4, 1'b0, 1'b1, 4);
        push(EvRunDn, 4, 1'b0, 1'b0, 5);
        state = 2'd1;
        tick(8);
        state = 2'd2;
        wait_sig(0, 4, 5, "recover_latency");
        state = 2'd1;
        drain("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
